slot_payout_ctrl: RTL and testbench

- Sits directly downstream of the reel spin/stop logic in the slot-machine top level.
- Gates each spin on available credit and deducts the bet.
- After the reels settle, evaluates the three final symbol indices against a fixed payout table and credits the win.
- Converts the credit balance to four BCD digits with a multi-cycle double-dabble converter, for the HEX3..HEX0 drivers.

---
 rtl/slot_payout_ctrl_if.sv | 27 ++
 rtl/slot_payout_ctrl.sv | 179 +++++++++++++++++
 tb/tb_slot_payout_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_payout_ctrl_if.sv
// Handshake bundle between the reel controller and slot_payout_ctrl.
// The reel controller side is the master; the payout controller is the slave.
interface slot_payout_ctrl_if;
  logic        spin_req;
  logic [1:0]  bet_sel;
  logic        spinning;
  logic [3:0]  sym_left;
  logic [3:0]  sym_center;
  logic [3:0]  sym_right;
  logic        spin_grant;
  logic [13:0] credits;
  logic [13:0] last_win;
  logic        win_flag;
  logic [15:0] bcd_digits;
  logic        bcd_valid;
  logic        busy;

  modport master (
    output spin_req, bet_sel, spinning, sym_left, sym_center, sym_right,
    input  spin_grant, credits, last_win, win_flag, bcd_digits, bcd_valid, busy
  );

  modport slave (
    input  spin_req, bet_sel, spinning, sym_left, sym_center, sym_right,
    output spin_grant, credits, last_win, win_flag, bcd_digits, bcd_valid, busy
  );
endinterface

// File: rtl/slot_payout_ctrl.sv
// Slot-machine credit controller: gates spins on credit, pays out from a fixed
// table and keeps a BCD copy of the balance via a shared double-dabble engine.
module slot_payout_ctrl #(
  parameter int INIT_CREDITS  = 100,
  parameter int MAX_CREDITS   = 9999,
  parameter int START_TIMEOUT = 1024
) (
  input logic               clk,
  input logic               rst,
  slot_payout_ctrl_if.slave bus
);
  localparam int              TW        = (START_TIMEOUT > 2) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [14:0]     MAX_SUM   = 15'(MAX_CREDITS);
  localparam logic [TW-1:0]   WAIT_LAST = TW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHARGE, WAIT_START, WAIT_STOP, EVAL, CREDIT, CONVERT
  } state_t;

  state_t      state;
  logic [13:0] credits;
  logic [13:0] last_win;
  logic        win_flag;
  logic        spin_grant;
  logic [15:0] bcd_digits;
  logic        bcd_valid;
  logic [2:0]  bet;
  logic [TW-1:0] wait_cnt;
  logic        spin_prev;
  logic [3:0]  sym_l, sym_c, sym_r;
  logic [3:0]  conv_cnt;
  logic [13:0] conv_shift;
  logic [15:0] conv_bcd;

  logic [2:0]  bet_new;
  logic [7:0]  mult;
  logic [13:0] payout;
  logic [14:0] win_sum;
  logic [14:0] refund_sum;
  logic        conv_on;
  logic [15:0] dd_next;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  function automatic logic [15:0] dd_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] a;
    a = b;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[14:0], in_bit};
  endfunction

  assign dd_next = dd_step(conv_bcd, conv_shift[13]);

  always_comb begin
    bet_new    = {1'b0, bus.bet_sel} + 3'd1;
    win_sum    = {1'b0, credits} + {1'b0, last_win};
    refund_sum = {1'b0, credits} + {12'd0, bet};
    conv_on    = (state inside {CONVERT, WAIT_START, WAIT_STOP}) && (conv_cnt != 4'd15);
    case (sym_l[2:0])
      3'd0:    mult = 8'd3;
      3'd1:    mult = 8'd5;
      3'd2:    mult = 8'd8;
      3'd3:    mult = 8'd10;
      3'd4:    mult = 8'd15;
      3'd5:    mult = 8'd20;
      3'd6:    mult = 8'd25;
      default: mult = 8'd50;
    endcase
    payout = '0;
    if (sym_l[3] || sym_c[3] || sym_r[3]) payout = '0;
    else if (sym_l == sym_c && sym_c == sym_r) payout = {6'd0, mult} * {11'd0, bet};
    else if (sym_l == sym_c || sym_c == sym_r) payout = {10'd0, bet, 1'b0};
  end

  // Converter steps run in the background of any converting state; later state
  // assignments that restart it (conv_cnt <= 0) take precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CONVERT;
      credits    <= 14'(INIT_CREDITS);
      last_win   <= '0;
      win_flag   <= 1'b0;
      spin_grant <= 1'b0;
      bcd_digits <= '0;
      bcd_valid  <= 1'b0;
      bet        <= 3'd1;
      wait_cnt   <= '0;
      spin_prev  <= 1'b0;
      sym_l      <= '0;
      sym_c      <= '0;
      sym_r      <= '0;
      conv_cnt   <= '0;
      conv_shift <= '0;
      conv_bcd   <= '0;
    end else begin
      spin_grant <= 1'b0;
      spin_prev  <= bus.spinning;
      win_flag   <= (last_win != '0);

      if (conv_on) begin
        if (conv_cnt == 4'd0) begin
          conv_shift <= credits;
          conv_bcd   <= '0;
        end else if (conv_cnt == 4'd14) begin
          bcd_digits <= dd_next;
          bcd_valid  <= 1'b1;
        end else begin
          conv_bcd   <= dd_next;
          conv_shift <= {conv_shift[12:0], 1'b0};
        end
        conv_cnt <= conv_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (bus.spin_req) state <= CHARGE;
        end
        CHARGE: begin
          bet <= bet_new;
          if (credits >= {11'd0, bet_new}) begin
            credits    <= credits - {11'd0, bet_new};
            spin_grant <= 1'b1;
            last_win   <= '0;
            wait_cnt   <= '0;
            conv_cnt   <= '0;
            bcd_valid  <= 1'b0;
            state      <= WAIT_START;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_START: begin
          if (bus.spinning) begin
            state <= WAIT_STOP;
          end else if (wait_cnt == WAIT_LAST) begin
            credits   <= (refund_sum > MAX_SUM) ? MAX_SUM[13:0] : refund_sum[13:0];
            conv_cnt  <= '0;
            bcd_valid <= 1'b0;
            state     <= CONVERT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WAIT_STOP: begin
          if (spin_prev && !bus.spinning) begin
            sym_l <= bus.sym_left;
            sym_c <= bus.sym_center;
            sym_r <= bus.sym_right;
            state <= EVAL;
          end
        end
        EVAL: begin
          last_win <= payout;
          conv_cnt <= '0;
          state    <= CREDIT;
        end
        CREDIT: begin
          credits   <= (win_sum > MAX_SUM) ? MAX_SUM[13:0] : win_sum[13:0];
          conv_cnt  <= '0;
          bcd_valid <= 1'b0;
          state     <= CONVERT;
        end
        CONVERT: begin
          if (conv_cnt == 4'd14) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spin_grant = spin_grant;
  assign bus.credits    = credits;
  assign bus.last_win   = last_win;
  assign bus.win_flag   = win_flag;
  assign bus.bcd_digits = bcd_digits;
  assign bus.bcd_valid  = bcd_valid;
  assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_slot_payout_ctrl.sv
// Self-checking bench for slot_payout_ctrl: directed and randomized spins
// compared against a payout/credit model built from the game rules.
module tb_slot_payout_ctrl;
  logic clk;
  logic rst;
  slot_payout_ctrl_if bus ();

  slot_payout_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks;
  int failures;
  int m_credits;
  int extra_grants;
  int mult_tab[8] = '{3, 5, 8, 10, 15, 20, 25, 50};

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int model_payout(input int l, input int c, input int r, input int b);
    if (l > 7 || c > 7 || r > 7) return 0;
    if (l == c && c == r) return mult_tab[l] * b;
    if (l == c || c == r) return 2 * b;
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic tick();
    @(negedge clk);
    if (bus.spin_grant) extra_grants++;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cycles && !done; k++) begin
      tick();
      if (!bus.busy && bus.bcd_valid) done = 1'b1;
    end
    if (!done) checkOutput("wait_idle_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_credits", 32'(bus.credits), 32'(100));
    checkOutput("rst_last_win", 32'(bus.last_win), 32'(0));
    checkOutput("rst_win_flag", 32'(bus.win_flag), 32'(0));
    checkOutput("rst_bcd_valid", 32'(bus.bcd_valid), 32'(0));
    checkOutput("rst_bcd_digits", 32'(bus.bcd_digits), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    m_credits = 100;
    wait_idle(40);
    checkOutput("rst_bcd_after", 32'(bus.bcd_digits), 32'(16'h0100));
  endtask

  // One complete spin request; spin_len=0 with no_spin=1 lets the start timeout expire.
  task automatic applyStimulus(input int bsel, input int l, input int c, input int r,
                               input int spin_len, input bit no_spin, input bit poke);
    int  b;
    int  pay;
    bit  ok;
    b = bsel + 1;
    ok = (m_credits >= b);
    extra_grants = 0;
    @(negedge clk);
    bus.bet_sel  = 2'(bsel);
    bus.spin_req = 1'b1;
    @(negedge clk);
    bus.spin_req = 1'b0;
    @(negedge clk);
    if (!ok) begin
      checkOutput("nogrant", 32'(bus.spin_grant), 32'(0));
      checkOutput("nocharge_credits", 32'(bus.credits), 32'(m_credits));
      checkOutput("nocharge_idle", 32'(bus.busy), 32'(0));
      checkOutput("nocharge_bcd", 32'(bus.bcd_digits), 32'(to_bcd(m_credits)));
      checkOutput("nocharge_valid", 32'(bus.bcd_valid), 32'(1));
      return;
    end
    checkOutput("grant", 32'(bus.spin_grant), 32'(1));
    checkOutput("charge_credits", 32'(bus.credits), 32'(m_credits - b));
    checkOutput("charge_bcd_valid", 32'(bus.bcd_valid), 32'(0));
    bus.bet_sel = 2'($urandom);
    m_credits = m_credits - b;
    if (no_spin) begin
      wait_idle(1200);
      m_credits = sat(m_credits + b);
      checkOutput("refund_credits", 32'(bus.credits), 32'(m_credits));
    end else begin
      tick();
      bus.spinning = 1'b1;
      for (int k = 0; k < spin_len; k++) begin
        tick();
        bus.spin_req = (poke && k == 2) ? 1'b1 : 1'b0;
      end
      bus.spin_req = 1'b0;
      if (spin_len >= 20) begin
        checkOutput("bg_bcd_valid", 32'(bus.bcd_valid), 32'(1));
        checkOutput("bg_bcd_digits", 32'(bus.bcd_digits), 32'(to_bcd(m_credits)));
      end
      bus.sym_left   = 4'(l);
      bus.sym_center = 4'(c);
      bus.sym_right  = 4'(r);
      bus.spinning   = 1'b0;
      pay = model_payout(l, c, r, b);
      wait_idle(200);
      m_credits = sat(m_credits + pay);
      checkOutput("win_credits", 32'(bus.credits), 32'(m_credits));
      checkOutput("last_win", 32'(bus.last_win), 32'(pay));
      checkOutput("win_flag", 32'(bus.win_flag), 32'(pay != 0));
    end
    checkOutput("end_bcd_digits", 32'(bus.bcd_digits), 32'(to_bcd(m_credits)));
    checkOutput("end_bcd_valid", 32'(bus.bcd_valid), 32'(1));
    checkOutput("single_grant", 32'(extra_grants), 32'(0));
  endtask

  initial begin
    int k;
    int mode, l, c, r;
    bit seen;
    checks = 0;
    failures = 0;
    extra_grants = 0;
    bus.spin_req = 1'b0;
    bus.bet_sel = 2'd0;
    bus.spinning = 1'b0;
    bus.sym_left = 4'd0;
    bus.sym_center = 4'd0;
    bus.sym_right = 4'd0;
    rst = 1'b1;
    #5 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("init_credits", 32'(bus.credits), 32'(100));
    checkOutput("init_bcd_valid", 32'(bus.bcd_valid), 32'(0));
    checkOutput("init_bcd_digits", 32'(bus.bcd_digits), 32'(0));
    checkOutput("init_grant", 32'(bus.spin_grant), 32'(0));
    rst = 1'b1;
    m_credits = 100;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 30) begin
      @(negedge clk);
      k++;
      if (bus.bcd_valid) seen = 1'b1;
    end
    checkOutput("reset_latency", 32'(k), 32'(15));
    checkOutput("reset_bcd", 32'(bus.bcd_digits), 32'(16'h0100));
    checkOutput("reset_busy", 32'(bus.busy), 32'(0));

    $display("[TB] directed spins");
    applyStimulus(3, 7, 7, 7, 20, 1'b0, 1'b1);
    checkOutput("jackpot_bcd", 32'(bus.bcd_digits), 32'(16'h0296));
    do_reset();
    applyStimulus(0, 2, 2, 5, 10, 1'b0, 1'b0);
    applyStimulus(0, 1, 3, 1, 5, 1'b0, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 1'b1, 1'b0);

    $display("[TB] random spins");
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        l = $urandom_range(0, 7); c = l; r = l;
      end else if (mode == 1) begin
        l = $urandom_range(0, 7); c = l; r = $urandom_range(0, 15);
      end else if (mode == 2) begin
        c = $urandom_range(0, 15); l = $urandom_range(0, 15); r = c;
      end else begin
        l = $urandom_range(0, 15); c = $urandom_range(0, 15); r = $urandom_range(0, 15);
      end
      applyStimulus($urandom_range(0, 3), l, c, r, $urandom_range(1, 24), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("[TB] drain to low and zero balance");
    do_reset();
    for (int i = 0; i < 24; i++) applyStimulus(3, 1, 3, 5, 2, 1'b0, 1'b0);
    applyStimulus(1, 1, 3, 5, 2, 1'b0, 1'b0);
    applyStimulus(3, 1, 3, 5, 2, 1'b0, 1'b0);
    applyStimulus(1, 1, 3, 5, 2, 1'b0, 1'b0);
    applyStimulus(0, 1, 3, 5, 2, 1'b0, 1'b0);
    checkOutput("zero_bcd", 32'(bus.bcd_digits), 32'(16'h0000));

    $display("[TB] climb to saturation");
    do_reset();
    for (int i = 0; i < 51; i++) applyStimulus(3, 7, 7, 7, 3, 1'b0, 1'b0);
    checkOutput("sat_bcd", 32'(bus.bcd_digits), 32'(16'h9999));

    $display("[TB] reset during spin");
    @(negedge clk);
    bus.bet_sel = 2'd3;
    bus.spin_req = 1'b1;
    @(negedge clk);
    bus.spin_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.spinning = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_credits", 32'(bus.credits), 32'(100));
    checkOutput("midrst_last_win", 32'(bus.last_win), 32'(0));
    checkOutput("midrst_bcd_valid", 32'(bus.bcd_valid), 32'(0));
    checkOutput("midrst_busy", 32'(bus.busy), 32'(1));
    bus.spinning = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_credits = 100;
    wait_idle(40);
    checkOutput("midrst_bcd", 32'(bus.bcd_digits), 32'(16'h0100));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
